id_hazard_ctrl: RTL
===================

# id_hazard_ctrl

Issue/stall controller for the decode (ID) stage. Keeps a per-register scoreboard of in-flight writes to the 32-entry register file and decides each cycle whether the instruction in IF/ID may issue. It stalls on source-operand hazards and write-counter saturation, and suppresses issue for a fixed window after a branch redirect (PCSource). It sits between the IF/ID register, the ID register file and the writeback port (writeEnable/writeSelect).

## Interface
- FLUSH_CYCLES, 2: cycles issue is blocked after a flush request (1..7)
- CNT_W, 2: width of each per-register pending-write counter
- STALL_CNT_W, 16: width of the stall-statistics counter
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  IF/ID holds a valid instruction
- issue_rs  in  5  first source register (readSelect1)
- issue_rt  in  5  second source register (readSelect2)
- issue_uses_rt  in  1  instruction reads rt
- issue_writes  in  1  instruction writes a register
- issue_dest  in  5  destination register
- wb_valid  in  1  writeback retires a write this cycle (writeEnable)
- wb_select  in  5  register being written back (writeSelect)
- flush  in  1  branch redirect (PCSource), single-cycle pulse
- issue_fire  out  1  instruction issues this cycle
- stall  out  1  issue_valid & ~issue_fire; holds IF/ID and PC
- busy  out  1  any pending-write counter nonzero
- state  out  2  FSM state: RUN=0, STALL=1, FLUSH=2
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- Scoreboard: pend[r] is a CNT_W-bit counter for r = 1..31. Register 0 has no counter and is never busy.
- Hazard, combinational from registered state: (rs≠0 & pend[rs]≠0) | (issue_uses_rt & rt≠0 & pend[rt]≠0) | (issue_writes & dest≠0 & pend[dest]=max).
- issue_fire = issue_valid & ~hazard & state≠FLUSH.
- Counter update on each edge:
  - +1 on pend[dest] if issue_fire & issue_writes & dest≠0.
  - −1 on pend[wb_select] if wb_valid & wb_select≠0 & pend≠0.
  - Increment and decrement of the same register in the same cycle: net unchanged.
  - Decrement at 0 is ignored. Increment at max cannot occur, because the hazard blocks it.
- FSM:
  - RUN → STALL when issue_valid & hazard.
  - STALL → RUN when hazard clears or issue_valid drops.
  - Any state → FLUSH on flush. Load fcnt = FLUSH_CYCLES−1.
  - FLUSH: fcnt decrements each cycle. Goes to RUN when fcnt = 0 and flush is low.
  - flush while in FLUSH reloads fcnt.
  - flush has priority over hazard transitions.
- Flush does not touch the scoreboard. Already-issued writes still retire.
- stall_count increments every cycle stall = 1 and saturates at all-ones.

## Timing
- Reset values: all pend = 0, state = RUN, fcnt = 0, stall_count = 0, issue_fire = 0, stall = 0, busy = 0.
- issue_fire and stall are combinational, zero latency, valid in the same cycle as the inputs.
- Scoreboard effects are visible the cycle after the edge.
- A dependent instruction issued one cycle after its producer sees pend = 1 and stalls.
- Reset asserted mid-stall or mid-flush clears everything asynchronously. Counts from in-flight writes are lost; the pipeline is reset together with this block.
- Flush latency: issue is blocked in the flush cycle itself (state still RUN, but the flush input forces issue_fire = 0 in that cycle) plus FLUSH_CYCLES following cycles.

## Configuration
- HAZ_WB_BYPASS_EN
  - Defined: a source or dest counter that is being decremented to 0 by wb_valid/wb_select in the same cycle counts as not busy. Issue proceeds because the register file writes before it reads.
  - Undefined: the hazard uses the registered pend only, which costs one extra stall cycle per dependency.

## Test plan
- Reset, then issue add r3←r1,r2 with no pending writes → issue_fire=1 the same cycle, pend[3]=1 the next cycle, busy=1.
- Producer writes r5. Next cycle a consumer reads rs=5; wb for r5 arrives 3 cycles later → stall=1 for 3 cycles (2 with HAZ_WB_BYPASS_EN), then fire. stall_count=3 (2).
- Three producers to r7 back-to-back with no wb, then a fourth → fourth stalls because pend[7]=3. One wb r7 → fourth fires next cycle and pend[7] stays 3.
- Issue writing r4 in the same cycle as wb r4 with pend[4]=1 → pend[4] stays 1.
- flush pulse with FLUSH_CYCLES=2 and issue_valid held high → issue_fire=0 for 3 cycles, state=FLUSH for 2 cycles, then RUN and fire.
- Destination or source r0 with wb_valid on r0 → never stalls and no counter changes. Reset asserted during STALL → all outputs return to reset values immediately.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage issue/stall controller with a per-register
// pending-write scoreboard, hazard stall and post-redirect flush window.
//
// Ports:
//   i_clk, i_reset        clock (rising edge), async active-high reset
//   i_issue_valid         IF/ID holds a valid instruction
//   i_issue_rs/rt         source registers (readSelect1/2)
//   i_issue_uses_rt       instruction reads rt
//   i_issue_writes/dest   instruction writes register dest
//   i_wb_valid/select     writeback retires a write (writeEnable/writeSelect)
//   i_flush               branch redirect pulse (PCSource)
//   o_issue_fire          instruction issues this cycle
//   o_stall               valid instruction held in IF/ID
//   o_busy                any pending write outstanding
//   o_state               RUN=0, STALL=1, FLUSH=2
//   o_stall_count         saturating stalled-cycle count
//
// Optional feature macro: HAZ_WB_BYPASS_EN
//   defined   : a counter retiring to zero this cycle is treated as free
//   undefined : hazards use the registered scoreboard only

module id_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_issue_valid,
    input  logic [4:0]             i_issue_rs,
    input  logic [4:0]             i_issue_rt,
    input  logic                   i_issue_uses_rt,
    input  logic                   i_issue_writes,
    input  logic [4:0]             i_issue_dest,
    input  logic                   i_wb_valid,
    input  logic [4:0]             i_wb_select,
    input  logic                   i_flush,
    output logic                   o_issue_fire,
    output logic                   o_stall,
    output logic                   o_busy,
    output logic [1:0]             o_state,
    output logic [STALL_CNT_W-1:0] o_stall_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [2:0]       FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

    // Scoreboard storage; register 0 has no counter.
    logic [CNT_W-1:0]       r_pend [1:31];
    logic [CNT_W-1:0]       w_pend [0:31];

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_fcnt;
    logic [2:0]             w_fcnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic [31:0]            w_nz;
    logic [31:0]            w_max;
    logic [31:0]            w_retire0;
    logic [31:0]            w_src_busy;
    logic [31:0]            w_dst_full;

    logic                   w_hazard;
    logic                   w_fire;
    logic                   w_stall;
    logic                   w_inc_en;
    logic                   w_dec_en;

    // Flat view with a constant-zero entry for r0 so selects index cleanly.
    always_comb begin
        w_pend[0] = '0;
        for (int i = 1; i < 32; i++) begin
            w_pend[i] = r_pend[i];
        end
    end

    always_comb begin
        w_nz  = '0;
        w_max = '0;
        for (int i = 1; i < 32; i++) begin
            w_nz[i]  = (w_pend[i] != '0);
            w_max[i] = (w_pend[i] == CNT_MAX);
        end
    end

    // Registers whose last outstanding write retires this very cycle.
    always_comb begin
        w_retire0 = '0;
`ifdef HAZ_WB_BYPASS_EN
        for (int i = 1; i < 32; i++) begin
            w_retire0[i] = i_wb_valid
                        && (i_wb_select == 5'(i))
                        && (w_pend[i] == CNT_W'(1));
        end
`else
        w_retire0 = '0;
`endif
    end

    assign w_src_busy = w_nz  & ~w_retire0;
    assign w_dst_full = w_max & ~w_retire0;

    // Dest hazard only at saturation: the counter must never wrap.
    assign w_hazard = w_src_busy[i_issue_rs]
                    | (i_issue_uses_rt & w_src_busy[i_issue_rt])
                    | (i_issue_writes  & w_dst_full[i_issue_dest]);

    // The flush cycle itself is blocked even though state is still RUN.
    assign w_fire = ~i_reset
                  & i_issue_valid
                  & ~w_hazard
                  & (r_state != ST_FLUSH)
                  & ~i_flush;

    assign w_stall = ~i_reset & i_issue_valid & ~w_fire;

    assign w_inc_en = w_fire & i_issue_writes & (i_issue_dest != 5'd0);
    assign w_dec_en = i_wb_valid
                    & (i_wb_select != 5'd0)
                    & w_nz[i_wb_select];

    for (genvar g = 1; g < 32; g++) begin : g_pend
        logic w_inc_g;
        logic w_dec_g;

        assign w_inc_g = w_inc_en && (i_issue_dest == 5'(g));
        assign w_dec_g = w_dec_en && (i_wb_select  == 5'(g));

        // Simultaneous issue and retire of the same register cancel.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                r_pend[g] <= '0;
            end else if (w_inc_g && !w_dec_g) begin
                r_pend[g] <= r_pend[g] + CNT_W'(1);
            end else if (w_dec_g && !w_inc_g) begin
                r_pend[g] <= r_pend[g] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        unique case (r_state)
            ST_RUN: begin
                if (i_issue_valid && w_hazard) begin
                    w_state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (!(i_issue_valid && w_hazard)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == 3'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = 3'd0;
            end
        endcase
        // Redirect wins over any hazard transition and restarts the window.
        if (i_flush) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = FCNT_LOAD;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign o_issue_fire  = w_fire;
    assign o_stall       = w_stall;
    assign o_busy        = |w_nz;
    assign o_state       = r_state;
    assign o_stall_count = r_stall_cnt;

endmodule
